mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8, address width in bits.
REQ-002 Parameter DW, default 8, data width in bits.
REQ-003 Parameter FIXED_PRIO, default 0; 0 = round-robin arbitration, 1 = port 0 always wins ties.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pN_req  input  1  port N (N = 0 CPU, 1 loader/DMA) access request; held high until pN_ack.
REQ-007 pN_we  input  1  port N write enable; 1 = write, 0 = read; stable while pN_req high.
REQ-008 pN_addr  input  AW  port N address; stable while pN_req high.
REQ-009 pN_wdata  input  DW  port N write data; stable while pN_req high.
REQ-010 pN_ack  output  1  port N one-cycle completion pulse.
REQ-011 pN_rdata  output  DW  port N read data.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-014 mem_addr  output  AW  memory address.
REQ-015 mem_wdata  output  DW  memory write data.
REQ-016 mem_rdata  input  DW  memory read data; synchronous, valid the cycle after a read strobe.
REQ-017 busy  output  1  high when the FSM is not in IDLE.
REQ-018 grant_id  output  1  port owning the current transaction; 0 in IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP, each lasting exactly one cycle except IDLE.
REQ-020 IDLE: if neither req is high, stay in IDLE; otherwise select a winner, register its we/addr/wdata and id, and go to ACCESS.
REQ-021 Single request: that port SHALL win regardless of mode.
REQ-022 Both requests, FIXED_PRIO=0: winner SHALL be the port not granted last (last_grant pointer); last_grant updates on entry to ACCESS.
REQ-023 Both requests, FIXED_PRIO=1: port 0 SHALL win.
REQ-024 ACCESS: mem_en=1; mem_we/mem_addr/mem_wdata SHALL be driven from the registered values; next state RESP.
REQ-025 RESP: ack SHALL be 1 for the granted port only; next state IDLE unconditionally.
REQ-026 Read in RESP: pN_rdata SHALL equal mem_rdata; a holding register SHALL capture it and drive pN_rdata afterwards until that port's next read ack.
REQ-027 Write: pN_rdata SHALL be unchanged; the write occurs at the edge ending ACCESS.
REQ-028 Latency: request seen in IDLE at cycle T SHALL produce ack in cycle T+2; minimum spacing between transactions SHALL be 3 cycles.
REQ-029 req still high in the cycle after ack SHALL be treated as a new request.
REQ-030 mem_en, mem_we and both acks SHALL be 0 outside ACCESS/RESP respectively; mem_addr/mem_wdata SHALL hold their last values.
REQ-031 Requests changing during ACCESS/RESP SHALL not alter the current transaction.
REQ-032 At most one ack SHALL be high in any cycle; no port SHALL be granted twice in a row while the other requests continuously (FIXED_PRIO=0).

Reset
REQ-033 reset SHALL force IDLE immediately, asynchronously, including mid-ACCESS or mid-RESP; the aborted transaction SHALL produce no ack.
REQ-034 Reset values: all outputs 0, holding registers 0, last_grant=1 so port 0 wins the first tie.

Verification
REQ-035 Reset, then p0 read addr 0x10 with memory holding 0x5A -> mem_en in cycle T+1 with addr 0x10, we=0; p0_ack and p0_rdata=0x5A in T+2; p0_rdata stays 0x5A afterwards.
REQ-036 p1 write addr 0x20, data 0xC3 -> mem_en=1, mem_we=1, addr 0x20, wdata 0xC3 in T+1; p1_ack in T+2; p1_rdata unchanged.
REQ-037 FIXED_PRIO=0, both ports requesting continuously for 6 transactions -> grant sequence 0,1,0,1,0,1, acks 3 cycles apart.
REQ-038 FIXED_PRIO=1, both ports requesting -> port 0 is granted every time while it holds req; port 1 is granted only after p0_req drops.
REQ-039 Assert reset during ACCESS -> mem_en drops in the same cycle, no ack is issued, busy=0; the next request completes normally.
REQ-040 Port 0 changes addr 0x10 to 0x11 during ACCESS -> mem_addr remains 0x10 through the transaction.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the memory-side strobes and the arbiter status.
// Handshake: a port raises pN_req with we/addr/wdata stable and holds it until the
// one-cycle pN_ack pulse; req still high in the cycle after ack is a fresh request.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          grant_id;
    logic [1:0]    dbg_state;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, grant_id, dbg_state
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, grant_id, dbg_state
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous memory: IDLE -> ACCESS -> RESP,
// round-robin or port-0-priority on ties, per-port read-data holding registers.
module mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic          gnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] hold0_q, hold1_q;
    logic          load;
    logic          winner;
    logic          in_resp_read;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        winner  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    load    = 1'b1;
                    state_d = ACCESS;
                    // On a tie, round-robin hands the slot to whoever was not served last.
                    if (bus.p0_req && bus.p1_req) winner = FIXED_PRIO ? 1'b0 : ~last_grant_q;
                    else                          winner = bus.p1_req;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            hold0_q      <= '0;
            hold1_q      <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                gnt_q        <= winner;
                last_grant_q <= winner;
                we_q         <= winner ? bus.p1_we    : bus.p0_we;
                addr_q       <= winner ? bus.p1_addr  : bus.p0_addr;
                wdata_q      <= winner ? bus.p1_wdata : bus.p0_wdata;
            end
            if (in_resp_read) begin
                if (gnt_q) hold1_q <= bus.mem_rdata;
                else       hold0_q <= bus.mem_rdata;
            end
        end
    end

    assign in_resp_read = (state_q == RESP) && !we_q;

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.p0_ack    = (state_q == RESP) && !gnt_q;
    assign bus.p1_ack    = (state_q == RESP) &&  gnt_q;
    assign bus.p0_rdata  = (in_resp_read && !gnt_q) ? bus.mem_rdata : hold0_q;
    assign bus.p1_rdata  = (in_resp_read &&  gnt_q) ? bus.mem_rdata : hold1_q;

    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = (state_q != IDLE) && gnt_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances, each behind a
// synchronous memory model whose reset contents are addr ^ 0x4A.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) rr_if ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) fp_if ();

    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .reset(reset), .bus(rr_if));
    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .reset(reset), .bus(fp_if));

    logic [DW-1:0] mem_rr [256];
    logic [DW-1:0] mem_fp [256];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_rr[i] <= 8'(i) ^ 8'h4A;
            rr_if.mem_rdata <= '0;
        end else if (rr_if.mem_en) begin
            if (rr_if.mem_we) mem_rr[rr_if.mem_addr] <= rr_if.mem_wdata;
            else              rr_if.mem_rdata <= mem_rr[rr_if.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_fp[i] <= 8'(i) ^ 8'h4A;
            fp_if.mem_rdata <= '0;
        end else if (fp_if.mem_en) begin
            if (fp_if.mem_we) mem_fp[fp_if.mem_addr] <= fp_if.mem_wdata;
            else              fp_if.mem_rdata <= mem_fp[fp_if.mem_addr];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] shadow [256];
    logic [7:0] hold0, hold1;
    logic [8:0] exp_q[$];

    task automatic init_model();
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h4A;
        hold0 = '0;
        hold1 = '0;
        exp_q.delete();
    endtask

    task automatic clear_inputs();
        rr_if.p0_req = 0; rr_if.p0_we = 0; rr_if.p0_addr = '0; rr_if.p0_wdata = '0;
        rr_if.p1_req = 0; rr_if.p1_we = 0; rr_if.p1_addr = '0; rr_if.p1_wdata = '0;
        fp_if.p0_req = 0; fp_if.p0_we = 0; fp_if.p0_addr = '0; fp_if.p0_wdata = '0;
        fp_if.p1_req = 0; fp_if.p1_we = 0; fp_if.p1_addr = '0; fp_if.p1_wdata = '0;
    endtask

    task automatic set_rr(input bit port, input logic req, input logic we,
                          input logic [7:0] addr, input logic [7:0] wdata);
        if (port) begin
            rr_if.p1_req = req; rr_if.p1_we = we; rr_if.p1_addr = addr; rr_if.p1_wdata = wdata;
        end else begin
            rr_if.p0_req = req; rr_if.p0_we = we; rr_if.p0_addr = addr; rr_if.p0_wdata = wdata;
        end
    endtask

    task automatic reset_all();
        @(posedge clk); #1;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        init_model();
    endtask

    // One isolated transaction on the round-robin instance, checked cycle by cycle.
    task automatic single_txn(input bit port, input logic we, input logic [7:0] addr,
                              input logic [7:0] wdata, input bit move_addr);
        logic [8:0] exp;
        logic [8:0] got;
        logic [7:0] hold_now;
        @(posedge clk); #1;
        hold_now = port ? hold1 : hold0;
        exp_q.push_back({port, we ? hold_now : shadow[addr]});
        set_rr(port, 1'b1, we, addr, wdata);

        @(negedge clk);
        tests_run++;
        if (rr_if.mem_en !== 1'b0 || rr_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL txn_idle: mem_en=%b busy=%b, required 0 0", rr_if.mem_en, rr_if.busy);
        end

        @(posedge clk); #1;
        if (move_addr) set_rr(port, 1'b1, we, addr + 8'd1, wdata);
        @(negedge clk);
        tests_run++;
        if (rr_if.mem_en !== 1'b1 || rr_if.mem_we !== we || rr_if.mem_addr !== addr ||
            rr_if.mem_wdata !== wdata || rr_if.grant_id !== port || rr_if.busy !== 1'b1 ||
            rr_if.p0_ack !== 1'b0 || rr_if.p1_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL txn_access: en=%b we=%b addr=%h wdata=%h gid=%b busy=%b acks=%b%b, required 1 %b %h %h %b 1 00",
                     rr_if.mem_en, rr_if.mem_we, rr_if.mem_addr, rr_if.mem_wdata, rr_if.grant_id,
                     rr_if.busy, rr_if.p1_ack, rr_if.p0_ack, we, addr, wdata, port);
        end

        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({rr_if.p1_ack, rr_if.p0_ack} !== (port ? 2'b10 : 2'b01) || rr_if.mem_en !== 1'b0 ||
            rr_if.mem_addr !== addr || rr_if.grant_id !== port) begin
            tests_failed++;
            $display("FAIL txn_resp: acks=%b%b en=%b addr=%h gid=%b, required ack port %0d en 0 addr %h",
                     rr_if.p1_ack, rr_if.p0_ack, rr_if.mem_en, rr_if.mem_addr, rr_if.grant_id, port, addr);
        end
        got = {port, port ? rr_if.p1_rdata : rr_if.p0_rdata};
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL txn_scoreboard: ack with empty expected queue");
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL txn_rdata: got %h, required %h", got, exp);
            end
        end
        if (we) shadow[addr] = wdata;
        else if (port) hold1 = shadow[addr];
        else hold0 = shadow[addr];

        @(posedge clk); #1;
        set_rr(port, 1'b0, we, addr, wdata);
        @(negedge clk);
        tests_run++;
        if (rr_if.p0_ack !== 1'b0 || rr_if.p1_ack !== 1'b0 || rr_if.busy !== 1'b0 ||
            rr_if.grant_id !== 1'b0 || rr_if.p0_rdata !== hold0 || rr_if.p1_rdata !== hold1) begin
            tests_failed++;
            $display("FAIL txn_after: acks=%b%b busy=%b gid=%b rd0=%h rd1=%h, required 00 0 0 %h %h",
                     rr_if.p1_ack, rr_if.p0_ack, rr_if.busy, rr_if.grant_id,
                     rr_if.p0_rdata, rr_if.p1_rdata, hold0, hold1);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        init_model();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({rr_if.p0_ack, rr_if.p1_ack, rr_if.mem_en, rr_if.mem_we, rr_if.busy, rr_if.grant_id,
             rr_if.p0_rdata, rr_if.p1_rdata, rr_if.mem_addr, rr_if.mem_wdata} !== 38'd0) begin
            tests_failed++;
            $display("FAIL reset_rr: outputs not all zero during reset (en=%b busy=%b addr=%h)",
                     rr_if.mem_en, rr_if.busy, rr_if.mem_addr);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({fp_if.p0_ack, fp_if.p1_ack, fp_if.mem_en, fp_if.mem_we, fp_if.busy, fp_if.grant_id,
             fp_if.p0_rdata, fp_if.p1_rdata, fp_if.mem_addr, fp_if.mem_wdata} !== 38'd0 ||
            rr_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_after: fp outputs nonzero or rr busy=%b, required all 0", rr_if.busy);
        end
    endtask

    task automatic test_read();
        single_txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
        tests_run++;
        if (rr_if.p0_rdata !== 8'h5A) begin
            tests_failed++;
            $display("FAIL read_hold: p0_rdata=%h, required 5a", rr_if.p0_rdata);
        end
    endtask

    task automatic test_write();
        single_txn(1'b1, 1'b1, 8'h20, 8'hC3, 1'b0);
        single_txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        tests_run++;
        if (rr_if.p1_rdata !== 8'hC3) begin
            tests_failed++;
            $display("FAIL write_readback: p1_rdata=%h, required c3", rr_if.p1_rdata);
        end
    endtask

    task automatic test_addr_hold();
        single_txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b1);
    endtask

    task automatic test_round_robin();
        int k;
        int last_ack;
        logic [8:0] exp;
        logic [8:0] got;
        bit ack_port;
        k = 0;
        last_ack = 0;
        reset_all();
        for (int i = 0; i < 6; i++)
            exp_q.push_back({i[0], i[0] ? shadow[8'h41] : shadow[8'h30]});
        set_rr(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
        set_rr(1'b1, 1'b1, 1'b0, 8'h41, 8'h00);
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            @(negedge clk);
            if (rr_if.p0_ack || rr_if.p1_ack) begin
                ack_port = rr_if.p1_ack;
                tests_run++;
                if ((rr_if.p0_ack && rr_if.p1_ack) || ack_port !== k[0]) begin
                    tests_failed++;
                    $display("FAIL rr_grant[%0d]: acks=%b%b, required port %0d", k, rr_if.p1_ack, rr_if.p0_ack, k[0]);
                end
                tests_run++;
                if (cyc != ((k == 0) ? 2 : last_ack + 3)) begin
                    tests_failed++;
                    $display("FAIL rr_spacing[%0d]: ack at cycle %0d, required %0d", k, cyc, (k == 0) ? 2 : last_ack + 3);
                end
                got = {ack_port, ack_port ? rr_if.p1_rdata : rr_if.p0_rdata};
                exp = exp_q.pop_front();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL rr_rdata[%0d]: got %h, required %h", k, got, exp);
                end
                last_ack = cyc;
                k++;
            end
            @(posedge clk);
        end
        #1 clear_inputs();
        tests_run++;
        if (k != 6) begin
            tests_failed++;
            $display("FAIL rr_timeout: %0d acks seen, required 6", k);
        end
        hold0 = shadow[8'h30];
        hold1 = shadow[8'h41];
        exp_q.delete();
    endtask

    task automatic test_fixed_prio();
        int k;
        int last_ack;
        bit ack_port;
        logic [7:0] got;
        k = 0;
        last_ack = 0;
        @(posedge clk); #1;
        fp_if.p0_req = 1'b1; fp_if.p0_we = 1'b0; fp_if.p0_addr = 8'h10;
        fp_if.p1_req = 1'b1; fp_if.p1_we = 1'b0; fp_if.p1_addr = 8'h20;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, (i == 3) ? 8'h6A : 8'h5A});
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            if (fp_if.p0_ack || fp_if.p1_ack) begin
                ack_port = fp_if.p1_ack;
                got = ack_port ? fp_if.p1_rdata : fp_if.p0_rdata;
                tests_run++;
                if ((fp_if.p0_ack && fp_if.p1_ack) || {ack_port, got} !== exp_q.pop_front() ||
                    cyc != ((k == 0) ? 2 : last_ack + 3)) begin
                    tests_failed++;
                    $display("FAIL fp_grant[%0d]: acks=%b%b rdata=%h cycle=%0d, required port %0d cycle %0d",
                             k, fp_if.p1_ack, fp_if.p0_ack, got, cyc, (k == 3) ? 1 : 0,
                             (k == 0) ? 2 : last_ack + 3);
                end
                last_ack = cyc;
                k++;
            end
            @(posedge clk);
            if (k == 3 && fp_if.p0_req) #1 fp_if.p0_req = 1'b0;
        end
        #1 clear_inputs();
        tests_run++;
        if (k != 4) begin
            tests_failed++;
            $display("FAIL fp_timeout: %0d acks seen, required 4", k);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        set_rr(1'b0, 1'b1, 1'b0, 8'h50, 8'h00);
        @(posedge clk); #1;
        tests_run++;
        if (rr_if.mem_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_access: mem_en=%b, required 1", rr_if.mem_en);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (rr_if.mem_en !== 1'b0 || rr_if.busy !== 1'b0 || rr_if.p0_ack !== 1'b0 ||
            rr_if.p1_ack !== 1'b0 || rr_if.grant_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_async: en=%b busy=%b acks=%b%b gid=%b, required all 0",
                     rr_if.mem_en, rr_if.busy, rr_if.p1_ack, rr_if.p0_ack, rr_if.grant_id);
        end
        set_rr(1'b0, 1'b0, 1'b0, 8'h50, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        init_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (rr_if.p0_ack !== 1'b0 || rr_if.p1_ack !== 1'b0 || rr_if.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort_noack[%0d]: acks=%b%b busy=%b, required 00 0",
                         i, rr_if.p1_ack, rr_if.p0_ack, rr_if.busy);
            end
        end
        single_txn(1'b0, 1'b0, 8'h50, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_addr_hold();
        test_round_robin();
        test_fixed_prio();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
